// File: rtl/branch_resolve_queue_pkg.sv
// Shared defines for the branch prediction slice.
// Holds the predictor PHT 2-bit state encodings together with the
// branch resolve queue sizing constants and the statistics counter width.
package branch_resolve_queue_pkg;

  // Two-bit pattern history table counter states.
  typedef enum logic [1:0] {
    PHT_STRONG_NT = 2'b00,
    PHT_WEAK_NT   = 2'b01,
    PHT_WEAK_T    = 2'b10,
    PHT_STRONG_T  = 2'b11
  } pht_state_e;

  localparam int BRQ_DEFAULT_DEPTH = 4;
  localparam int BRQ_DEFAULT_PTR_W = $clog2(BRQ_DEFAULT_DEPTH);
  localparam int BRQ_STAT_W        = 16;

  // Prediction direction carried by a PHT state: taken for the upper half.
  function automatic logic pht_predict(input pht_state_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/branch_resolve_queue_sat_counter16.sv
// sat_counter16: 16-bit enable counter that sticks at all-ones.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears the count
//   en_i - count one event this cycle
//   cnt_o - current count
module sat_counter16
  import branch_resolve_queue_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  output logic [BRQ_STAT_W-1:0] cnt_o
);

  logic [BRQ_STAT_W-1:0] cnt_q;
  logic [BRQ_STAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {BRQ_STAT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of predicted conditional branches.
// Fetch pushes {pc, predicted direction}; execute resolves the oldest entry
// with the actual direction. Each accepted resolution produces a registered
// predictor update one cycle later, and a mispredict flushes every entry as
// wrong-path.
// Ports:
//   clk, rst                 - clock and asynchronous active-low reset
//   push_valid/pc/pred_taken - branch issued by fetch
//   push_ready               - queue not full
//   res_valid/res_taken      - resolution of the oldest branch
//   res_ready                - queue not empty
//   upd_valid/pc/taken       - predictor update strobe and write data
//   mispredict               - one-cycle pulse alongside a wrong update
//   count                    - occupancy
//   branch_cnt/mispredict_cnt - saturating statistics
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEFAULT_DEPTH,
  parameter int PC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     push_pred_taken,
  output logic                     push_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic [BRQ_STAT_W-1:0]    branch_cnt,
  output logic [BRQ_STAT_W-1:0]    mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PC_W-1:0]  pcMem   [DEPTH];
  logic             predMem [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             updValid_q, updTaken_q, mispredict_q;
  logic [PC_W-1:0]  updPc_q;

  logic pushAcc, resAcc, resMiss;

  // Handshake readiness comes only from registered occupancy.
  assign push_ready = (count_q != FULL_CNT);
  assign res_ready  = (count_q != '0);

  assign pushAcc = push_valid && push_ready;
  assign resAcc  = res_valid && res_ready;
  assign resMiss = resAcc && (predMem[rdPtr_q] != res_taken);

  // A mispredict collapses the queue: the read pointer jumps to the write
  // pointer and any same-cycle push is dropped as wrong-path.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (resMiss) begin
      rdPtr_d = wrPtr_q;
      count_d = '0;
    end else begin
      if (pushAcc) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (resAcc) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, pushAcc} - {{PTR_W{1'b0}}, resAcc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (pushAcc && !resMiss) begin
      pcMem[wrPtr_q]   <= push_pc;
      predMem[wrPtr_q] <= push_pred_taken;
    end
  end

  // Update data is captured only on accepted resolutions so it holds
  // its last value between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      updValid_q   <= 1'b0;
      updPc_q      <= '0;
      updTaken_q   <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      updValid_q   <= resAcc;
      mispredict_q <= resMiss;
      if (resAcc) begin
        updPc_q    <= pcMem[rdPtr_q];
        updTaken_q <= res_taken;
      end
    end
  end

  assign upd_valid  = updValid_q;
  assign upd_pc     = updPc_q;
  assign upd_taken  = updTaken_q;
  assign mispredict = mispredict_q;
  assign count      = count_q;

  sat_counter16 uBranchCnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (resAcc),
    .cnt_o (branch_cnt)
  );

  sat_counter16 uMispredictCnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (resMiss),
    .cnt_o (mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Testbench for branch_resolve_queue: directed scenarios plus randomized
// traffic, all compared against a queue-based model of the branch queue.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 16;

  logic             clk;
  logic             rst;
  logic             pushValid;
  logic [PC_W-1:0]  pushPc;
  logic             pushPredTaken;
  logic             pushReady;
  logic             resValid;
  logic             resTaken;
  logic             resReady;
  logic             updValid;
  logic [PC_W-1:0]  updPc;
  logic             updTaken;
  logic             mispredict;
  logic [2:0]       count;
  logic [15:0]      branchCnt;
  logic [15:0]      mispredictCnt;

  int vectors;
  int miscompares;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            pred;
  } entry_t;

  entry_t          mQueue[$];
  int              mBranch;
  int              mMiss;
  logic            expUpdValid;
  logic [PC_W-1:0] expUpdPc;
  logic            expUpdTaken;
  logic            expMiss;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .push_valid      (pushValid),
    .push_pc         (pushPc),
    .push_pred_taken (pushPredTaken),
    .push_ready      (pushReady),
    .res_valid       (resValid),
    .res_taken       (resTaken),
    .res_ready       (resReady),
    .upd_valid       (updValid),
    .upd_pc          (updPc),
    .upd_taken       (updTaken),
    .mispredict      (mispredict),
    .count           (count),
    .branch_cnt      (branchCnt),
    .mispredict_cnt  (mispredictCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one clock: readiness from the occupancy before the edge,
  // the oldest entry is resolved, a wrong direction empties the queue.
  task automatic model_step(input logic pv, input logic [PC_W-1:0] pc,
                            input logic pt, input logic rv, input logic rt);
    bit full, empty, pushOk, resOk, miss;
    entry_t e;
    full   = (mQueue.size() == DEPTH);
    empty  = (mQueue.size() == 0);
    pushOk = pv && !full;
    resOk  = rv && !empty;
    miss   = 1'b0;
    expUpdValid = resOk;
    expMiss     = 1'b0;
    if (resOk) begin
      e = mQueue.pop_front();
      miss = (e.pred != rt);
      expUpdPc    = e.pc;
      expUpdTaken = rt;
      expMiss     = miss;
      if (mBranch < 65535) mBranch++;
      if (miss && mMiss < 65535) mMiss++;
      if (miss) mQueue.delete();
    end
    if (pushOk && !miss) begin
      e.pc = pc;
      e.pred = pt;
      mQueue.push_back(e);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and leave the bench
  // sampling 1 time unit after the rising edge with inputs idle.
  task automatic drive(input logic pv, input logic [PC_W-1:0] pc,
                       input logic pt, input logic rv, input logic rt);
    pushValid     = pv;
    pushPc        = pc;
    pushPredTaken = pt;
    resValid      = rv;
    resTaken      = rt;
    model_step(pv, pc, pt, rv, rt);
    @(posedge clk);
    #1;
    pushValid = 1'b0;
    resValid  = 1'b0;
  endtask

  task automatic model_reset();
    mQueue.delete();
    mBranch     = 0;
    mMiss       = 0;
    expUpdValid = 1'b0;
    expUpdPc    = '0;
    expUpdTaken = 1'b0;
    expMiss     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pushValid = 1'b0; pushPc = '0; pushPredTaken = 1'b0;
    resValid = 1'b0; resTaken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (pushReady !== 1'b1 || resReady !== 1'b0 || count !== 3'd0 || updValid !== 1'b0
        || mispredict !== 1'b0 || branchCnt !== 16'd0 || mispredictCnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: pr=%b rr=%b cnt=%0d uv=%b mp=%b bc=%0d mc=%0d required pr=1 rr=0 cnt=0 uv=0 mp=0 bc=0 mc=0",
               pushReady, resReady, count, updValid, mispredict, branchCnt, mispredictCnt);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    drive(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (updValid !== 1'b1 || updPc !== 16'h0040 || updTaken !== 1'b1 || mispredict !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL basic_update: uv=%b pc=%h t=%b mp=%b cnt=%0d required 1 0040 1 0 0",
               updValid, updPc, updTaken, mispredict, count);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (updValid !== 1'b0 || updPc !== 16'h0040 || updTaken !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL update_hold: uv=%b pc=%h t=%b required 0 0040 1", updValid, updPc, updTaken);
    end
  endtask

  task automatic test_full();
    logic [PC_W-1:0] pcs [4];
    pcs[0] = 16'h0010; pcs[1] = 16'h0014; pcs[2] = 16'h0018; pcs[3] = 16'h001C;
    for (int i = 0; i < 4; i++) drive(1'b1, pcs[i], 1'b1, 1'b0, 1'b0);
    vectors++;
    if (pushReady !== 1'b0 || count !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL full_flag: pr=%b cnt=%0d required pr=0 cnt=4", pushReady, count);
    end
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL push_when_full: cnt=%0d required 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (updValid !== 1'b1 || updPc !== pcs[i] || mispredict !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL in_order_%0d: uv=%b pc=%h mp=%b required 1 %h 0", i, updValid, updPc, mispredict, pcs[i]);
      end
    end
  endtask

  task automatic test_mispredict();
    drive(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0104, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0108, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (mispredict !== 1'b1 || updTaken !== 1'b1 || updPc !== 16'h0100 || count !== 3'd0
        || mispredictCnt !== 16'd1 || resReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mispredict_flush: mp=%b t=%b pc=%h cnt=%0d mc=%0d rr=%b required 1 1 0100 0 1 0",
               mispredict, updTaken, updPc, count, mispredictCnt, resReady);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0204, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0208, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (count !== 3'd2 || updPc !== 16'h0200 || mispredict !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL push_and_resolve: cnt=%0d pc=%h mp=%b required 2 0200 0", count, updPc, mispredict);
    end
    drive(1'b1, 16'h020C, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (count !== 3'd0 || mispredict !== 1'b1 || updPc !== 16'h0204) begin
      miscompares++;
      $display("[TB] FAIL push_dropped_on_flush: cnt=%0d mp=%b pc=%h required 0 1 0204", count, mispredict, updPc);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0300 + 16'(4 * i), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0310, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (count !== 3'd3 || updPc !== 16'h0300 || pushReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_push_and_resolve: cnt=%0d pc=%h pr=%b required 3 0300 1", count, updPc, pushReady);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_empty_and_async_reset();
    logic [15:0] bcBefore;
    bcBefore = branchCnt;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (updValid !== 1'b0 || mispredict !== 1'b0 || branchCnt !== bcBefore) begin
      miscompares++;
      $display("[TB] FAIL resolve_empty: uv=%b mp=%b bc=%0d required 0 0 %0d", updValid, mispredict, branchCnt, bcBefore);
    end
    drive(1'b1, 16'h0400, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0404, 1'b1, 1'b1, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || updValid !== 1'b0 || branchCnt !== 16'd0 || updPc !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: cnt=%0d uv=%b bc=%0d pc=%h required 0 0 0 0000", count, updValid, branchCnt, updPc);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (updValid !== 1'b0 || count !== 3'd0 || mispredict !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL post_reset_%0d: uv=%b cnt=%0d mp=%b required 0 0 0", i, updValid, count, mispredict);
      end
    end
  endtask

  task automatic test_random();
    logic pv, pt, rv, rt;
    logic [PC_W-1:0] pc;
    for (int i = 0; i < 400; i++) begin
      pv = 1'($urandom_range(0, 3) != 0);
      pt = 1'($urandom);
      rv = 1'($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 5) == 0) ? ~mQueue[0].pred : 1'($urandom);
      if (mQueue.size() != 0 && $urandom_range(0, 1) == 1) rt = mQueue[0].pred;
      pc = 16'($urandom);
      vectors++;
      if (pushReady !== (mQueue.size() != DEPTH) || resReady !== (mQueue.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL rand_ready_%0d: pr=%b rr=%b size=%0d", i, pushReady, resReady, mQueue.size());
      end
      drive(pv, pc, pt, rv, rt);
      vectors++;
      if (updValid !== expUpdValid || mispredict !== expMiss || count !== 3'(mQueue.size())
          || updPc !== expUpdPc || updTaken !== expUpdTaken
          || branchCnt !== 16'(mBranch) || mispredictCnt !== 16'(mMiss)) begin
        miscompares++;
        $display("[TB] FAIL rand_%0d: uv=%b mp=%b cnt=%0d pc=%h t=%b bc=%0d mc=%0d required %b %b %0d %h %b %0d %0d",
                 i, updValid, mispredict, count, updPc, updTaken, branchCnt, mispredictCnt,
                 expUpdValid, expMiss, mQueue.size(), expUpdPc, expUpdTaken, mBranch, mMiss);
      end
    end
  endtask

  task automatic test_saturate();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    while (mQueue.size() != 0) drive(1'b0, '0, 1'b0, 1'b1, mQueue[0].pred);
    drive(1'b1, 16'h0500, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) drive(1'b1, 16'h0500, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (branchCnt !== 16'hFFFF || branchCnt !== 16'(mBranch) || mispredictCnt !== 16'(mMiss) || count !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL saturate: bc=%h mc=%0d cnt=%0d required FFFF %0d 1", branchCnt, mispredictCnt, count, mMiss);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_back_to_back();
    test_empty_and_async_reset();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
